stream_rr_credit_arb: RTL and testbench
=======================================

Name: stream_rr_credit_arb

Overview:
Round-robin arbiter that lets N_INP requester streams share one downstream stream FIFO. It enforces a credit budget equal to the FIFO depth, so the number of in-flight items never exceeds the FIFO capacity. The output is a single valid/ready stream carrying the payload and the source index. It sits directly in front of the shared stream FIFO in the axi_to_mem request path. The downstream consumer returns one credit per item it pops.

Parameters:
N_INP, 4, number of requester streams (>=2)
DATA_WIDTH, 2, payload width per requester
CREDITS, 8, initial and maximum credit count; equals downstream FIFO DEPTH (>=1)
IDX_WIDTH, $clog2(N_INP), width of the source index
CNT_WIDTH, $clog2(CREDITS+1), width of the credit counter

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  synchronous clear of arbitration and credit state
inp_data_i  in  N_INP*DATA_WIDTH  payloads; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
inp_valid_i  in  N_INP  per-requester valid
inp_ready_o  out  N_INP  per-requester ready
oup_data_o  out  DATA_WIDTH  granted payload
oup_idx_o  out  IDX_WIDTH  granted requester index
oup_valid_o  out  1  output valid
oup_ready_i  in  1  downstream ready (FIFO ~full)
credit_return_i  in  1  one-cycle pulse; downstream popped one item
credits_o  out  CNT_WIDTH  current credit count
credit_err_o  out  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- Reset is synchronous (rst_ni=0 sampled at the edge). On that edge: rr_q=0, lock_q=0, lock_idx_q=0, cnt_q=CREDITS, err_q=0. While rst_ni=0, oup_valid_o=0 and inp_ready_o=0 combinationally.
- After reset: credits_o=CREDITS, credit_err_o=0, oup_idx_o=0, oup_data_o=requester 0 payload.
- Grant is combinational, with zero latency from input to output.
- Unlocked grant: the first index g in the order rr_q, rr_q+1, ..., N_INP-1, 0, ..., rr_q-1 with inp_valid_i[g]=1.
- If no requester is valid: g=rr_q and oup_valid_o=0.
- oup_valid_o = inp_valid_i[g] & (cnt_q!=0) & rst_ni & ~flush_i.
- oup_data_o and oup_idx_o always follow g.
- inp_ready_o[k] = (k==g) & oup_ready_i & (cnt_q!=0) & rst_ni & ~flush_i. All other bits are 0.
- Transfer: oup_valid_o & oup_ready_i. Exactly one input handshakes in the same cycle.
- On transfer: rr_q <= (g==N_INP-1) ? 0 : g+1, and lock_q <= 0.
- Lock (stream stability): if oup_valid_o=1 and oup_ready_i=0 at an edge, then lock_q<=1 and lock_idx_q<=g.
- While lock_q=1, g=lock_idx_q regardless of other valids. rr_q does not change.
- Requesters must hold valid and data stable until ready (protocol rule). A bench assertion flags a locked requester dropping valid.
- Credit counter:
  - transfer only: cnt_q-1.
  - credit_return_i only: cnt_q+1, saturating at CREDITS.
  - both in the same cycle: unchanged.
  - credit_return_i with cnt_q==CREDITS and no transfer: cnt_q stays at CREDITS and err_q<=1.
- cnt_q==0 blocks oup_valid_o. A lock cannot form at 0 credits, because credits only decrease on a transfer.
- credits_o=cnt_q and credit_err_o=err_q, both registered.
- flush_i=1 has the reset effect on rr_q, lock_q, lock_idx_q, cnt_q and err_q at the edge. During the flush cycle, oup_valid_o=0 and inp_ready_o=0.
- Simultaneous credit_return_i and flush_i: flush wins and cnt_q=CREDITS.
- Reset mid-lock: the lock is dropped and the next grant restarts from index 0.
- Priority: rst_ni > flush_i > normal operation.

Test Plan:
1. Reset, then all 4 requesters valid, oup_ready_i=1, credit_return_i echoing every transfer: oup_idx_o sequence 0,1,2,3,0,... at one item/cycle; credits_o stays 8 after the first return.
2. Requesters 1 and 3 valid, ready=0 for 3 cycles with g=1, then requester 0 asserts valid: oup_idx_o stays 1 throughout the stall. When ready=1: transfer idx 1, then 3, then 0.
3. Requester 2 valid continuously, ready=1, no credit returns: exactly 8 transfers. Then oup_valid_o=0, inp_ready_o=0000, credits_o=0. One credit_return_i pulse allows exactly one more transfer.
4. credits_o=5 with a transfer and credit_return_i in the same cycle: credits_o stays 5. Credit pulse at credits_o=8 with no transfer: credits_o=8 and credit_err_o=1, held until flush.
5. Locked on idx 2 with credits_o=3, then flush_i=1 for 1 cycle: during the flush cycle oup_valid_o=0. Next cycle: credits_o=8, credit_err_o=0, lock cleared, arbitration restarts at idx 0.
6. rst_ni=0 for 2 cycles mid-stream with valids held: oup_valid_o=0 and inp_ready_o=0 during reset. After release: first grant is the lowest valid index from 0, and credits_o=8.

Source files
------------

// File: rtl/stream_rr_credit_arb.sv
// Round-robin arbiter merging N_INP valid/ready streams into one output stream,
// gated by a credit budget that mirrors the free space of the downstream FIFO.
module stream_rr_credit_arb #(
    parameter int unsigned N_INP      = 4,
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned CREDITS    = 8,
    parameter int unsigned IDX_WIDTH  = $clog2(N_INP),
    parameter int unsigned CNT_WIDTH  = $clog2(CREDITS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    output logic [DATA_WIDTH-1:0]       oup_data_o,
    output logic [IDX_WIDTH-1:0]        oup_idx_o,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    input  logic                        credit_return_i,
    output logic [CNT_WIDTH-1:0]        credits_o,
    output logic                        credit_err_o
);

    localparam logic [IDX_WIDTH:0]     N_EXT    = (IDX_WIDTH + 1)'(N_INP);
    localparam logic [IDX_WIDTH-1:0]   IDX_LAST = IDX_WIDTH'(N_INP - 1);
    localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = CNT_WIDTH'(CREDITS);

    logic [IDX_WIDTH-1:0] rr_q, rr_d;
    logic                 lock_q, lock_d;
    logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [N_INP-1:0][DATA_WIDTH-1:0] data_arr;
    logic [IDX_WIDTH-1:0]             cand [N_INP];
    logic [IDX_WIDTH-1:0]             unlocked_g;
    logic [IDX_WIDTH-1:0]             g;
    logic                             active;
    logic                             xfer;

    assign data_arr = inp_data_i;

    // cand[i] is the i-th index in round-robin order starting at rr_q.
    for (genvar gi = 0; gi < N_INP; gi++) begin : g_cand
        logic [IDX_WIDTH:0] sum;
        assign sum      = {1'b0, rr_q} + (IDX_WIDTH + 1)'(gi);
        assign cand[gi] = (sum >= N_EXT) ? IDX_WIDTH'(sum - N_EXT) : IDX_WIDTH'(sum);
    end

    // Scan from the back so the earliest valid candidate wins.
    always_comb begin
        unlocked_g = rr_q;
        for (int i = N_INP - 1; i >= 0; i--) begin
            if (inp_valid_i[cand[i]]) begin
                unlocked_g = cand[i];
            end
        end
    end

    assign g           = lock_q ? lock_idx_q : unlocked_g;
    assign active      = rst_ni & ~flush_i & (cnt_q != '0);
    assign oup_valid_o = inp_valid_i[g] & active;
    assign oup_data_o  = data_arr[g];
    assign oup_idx_o   = g;
    assign xfer        = oup_valid_o & oup_ready_i;

    for (genvar gi = 0; gi < N_INP; gi++) begin : g_ready
        assign inp_ready_o[gi] = (g == IDX_WIDTH'(gi)) & oup_ready_i & active;
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if (flush_i) begin
            rr_d       = '0;
            lock_d     = 1'b0;
            lock_idx_d = '0;
            cnt_d      = CNT_MAX;
            err_d      = 1'b0;
        end else begin
            if (xfer) begin
                rr_d   = (g == IDX_LAST) ? '0 : g + IDX_WIDTH'(1);
                lock_d = 1'b0;
            end else if (oup_valid_o) begin
                // Stalled offer: hold this grant until it is accepted.
                lock_d     = 1'b1;
                lock_idx_d = g;
            end
            if (xfer && !credit_return_i) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (credit_return_i && !xfer) begin
                if (cnt_q == CNT_MAX) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= CNT_MAX;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign credits_o    = cnt_q;
    assign credit_err_o = err_q;

endmodule

// File: tb/tb_stream_rr_credit_arb.sv
// Directed bench for stream_rr_credit_arb: round-robin order, locking on stall,
// credit exhaustion and saturation, flush and mid-lock reset.
module tb_stream_rr_credit_arb;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic [7:0] inp_data_i;
    logic [3:0] inp_valid_i;
    logic [3:0] inp_ready_o;
    logic [1:0] oup_data_o;
    logic [1:0] oup_idx_o;
    logic       oup_valid_o;
    logic       oup_ready_i;
    logic       credit_return_i;
    logic [3:0] credits_o;
    logic       credit_err_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    stream_rr_credit_arb dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .inp_data_i     (inp_data_i),
        .inp_valid_i    (inp_valid_i),
        .inp_ready_o    (inp_ready_o),
        .oup_data_o     (oup_data_o),
        .oup_idx_o      (oup_idx_o),
        .oup_valid_o    (oup_valid_o),
        .oup_ready_i    (oup_ready_i),
        .credit_return_i(credit_return_i),
        .credits_o      (credits_o),
        .credit_err_o   (credit_err_o)
    );

    // Protocol monitor: an offer stalled at an edge must stay valid afterwards.
    logic       stall_q = 1'b0;
    logic [1:0] stall_idx_q = '0;
    always @(posedge clk) begin
        stall_q     <= oup_valid_o & ~oup_ready_i & rst_ni & ~flush_i;
        stall_idx_q <= oup_idx_o;
    end
    always @(negedge clk) begin
        if (stall_q && rst_ni && !inp_valid_i[stall_idx_q]) begin
            errors++;
            $display("FAIL lock_hold: requester %0d dropped valid while locked", stall_idx_q);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Payload of requester k is 3-k so data and index mismatches are distinct.
        inp_data_i      = 8'b00_01_10_11;
        rst_ni          = 1'b0;
        flush_i         = 1'b0;
        inp_valid_i     = 4'b1111;
        oup_ready_i     = 1'b1;
        credit_return_i = 1'b0;
        tick();
        #1;
        chk("rst_valid", 32'(oup_valid_o), 0);
        chk("rst_ready", 32'(inp_ready_o), 0);
        tick();

        // 1: all valid, returns echo every transfer
        rst_ni          = 1'b1;
        credit_return_i = 1'b1;
        #1;
        chk("t1_credits_init", 32'(credits_o), 8);
        chk("t1_err_init", 32'(credit_err_o), 0);
        for (int i = 0; i < 8; i++) begin
            chk("t1_idx", 32'(oup_idx_o), i % 4);
            chk("t1_data", 32'(oup_data_o), 3 - (i % 4));
            chk("t1_valid", 32'(oup_valid_o), 1);
            chk("t1_ready", 32'(inp_ready_o), 1 << (i % 4));
            tick();
            chk("t1_credits", 32'(credits_o), 8);
        end

        // 2: stall on 1 with 1,3 valid; requester 0 joins mid-stall
        credit_return_i = 1'b0;
        oup_ready_i     = 1'b0;
        inp_valid_i     = 4'b1010;
        #1;
        chk("t2_idx_s0", 32'(oup_idx_o), 1);
        chk("t2_ready_s0", 32'(inp_ready_o), 0);
        tick();
        inp_valid_i = 4'b1011;
        #1;
        chk("t2_idx_s1", 32'(oup_idx_o), 1);
        tick();
        chk("t2_idx_s2", 32'(oup_idx_o), 1);
        chk("t2_valid_s2", 32'(oup_valid_o), 1);
        tick();
        oup_ready_i = 1'b1;
        #1;
        chk("t2_xfer_a", 32'(oup_idx_o), 1);
        chk("t2_ready_a", 32'(inp_ready_o), 4'b0010);
        tick();
        inp_valid_i = 4'b1001;
        #1;
        chk("t2_xfer_b", 32'(oup_idx_o), 3);
        tick();
        inp_valid_i = 4'b0001;
        #1;
        chk("t2_xfer_c", 32'(oup_idx_o), 0);
        tick();
        chk("t2_credits", 32'(credits_o), 5);

        // 4: simultaneous transfer and return, then saturation error
        credit_return_i = 1'b1;
        #1;
        chk("t4_xfer_valid", 32'(oup_valid_o), 1);
        tick();
        chk("t4_credits_same", 32'(credits_o), 5);
        inp_valid_i = 4'b0000;
        tick();
        tick();
        tick();
        chk("t4_credits_full", 32'(credits_o), 8);
        chk("t4_err_pre", 32'(credit_err_o), 0);
        tick();
        chk("t4_credits_sat", 32'(credits_o), 8);
        chk("t4_err_set", 32'(credit_err_o), 1);
        credit_return_i = 1'b0;
        tick();
        chk("t4_err_hold", 32'(credit_err_o), 1);

        // 3: requester 2 drains all credits
        inp_valid_i = 4'b0100;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("t3_valid", 32'(oup_valid_o), 1);
            chk("t3_idx", 32'(oup_idx_o), 2);
            chk("t3_credits", 32'(credits_o), 8 - i);
            tick();
        end
        chk("t3_empty_valid", 32'(oup_valid_o), 0);
        chk("t3_empty_ready", 32'(inp_ready_o), 0);
        chk("t3_empty_credits", 32'(credits_o), 0);
        credit_return_i = 1'b1;
        tick();
        credit_return_i = 1'b0;
        #1;
        chk("t3_one_valid", 32'(oup_valid_o), 1);
        chk("t3_one_ready", 32'(inp_ready_o), 4'b0100);
        chk("t3_one_credits", 32'(credits_o), 1);
        tick();
        chk("t3_again_valid", 32'(oup_valid_o), 0);
        chk("t3_again_credits", 32'(credits_o), 0);

        // 5: lock on 2 with 3 credits, then flush
        inp_valid_i     = 4'b0000;
        credit_return_i = 1'b1;
        tick();
        tick();
        tick();
        credit_return_i = 1'b0;
        oup_ready_i     = 1'b0;
        inp_valid_i     = 4'b0100;
        #1;
        chk("t5_credits", 32'(credits_o), 3);
        chk("t5_idx", 32'(oup_idx_o), 2);
        tick();
        inp_valid_i = 4'b0101;
        #1;
        chk("t5_locked_idx", 32'(oup_idx_o), 2);
        chk("t5_err_before", 32'(credit_err_o), 1);
        flush_i     = 1'b1;
        oup_ready_i = 1'b1;
        credit_return_i = 1'b1;
        #1;
        chk("t5_flush_valid", 32'(oup_valid_o), 0);
        chk("t5_flush_ready", 32'(inp_ready_o), 0);
        tick();
        flush_i         = 1'b0;
        credit_return_i = 1'b0;
        oup_ready_i     = 1'b0;
        #1;
        chk("t5_post_credits", 32'(credits_o), 8);
        chk("t5_post_err", 32'(credit_err_o), 0);
        chk("t5_post_idx", 32'(oup_idx_o), 0);
        chk("t5_post_valid", 32'(oup_valid_o), 1);

        // 6: reset while locked on 2
        inp_valid_i = 4'b0110;
        oup_ready_i = 1'b1;
        #1;
        chk("t6_first", 32'(oup_idx_o), 1);
        tick();
        oup_ready_i = 1'b0;
        #1;
        chk("t6_lock_idx", 32'(oup_idx_o), 2);
        tick();
        chk("t6_credits_pre", 32'(credits_o), 7);
        rst_ni      = 1'b0;
        oup_ready_i = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(oup_valid_o), 0);
        chk("t6_rst_ready", 32'(inp_ready_o), 0);
        tick();
        chk("t6_rst_valid2", 32'(oup_valid_o), 0);
        tick();
        rst_ni = 1'b1;
        #1;
        chk("t6_post_idx", 32'(oup_idx_o), 1);
        chk("t6_post_ready", 32'(inp_ready_o), 4'b0010);
        chk("t6_post_credits", 32'(credits_o), 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
